// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding, digit
// correction constants and elaboration-time helpers.
package bin_to_bcd_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX_NIBBLE = 4'd9;
    localparam logic [3:0] ADJ_THRESHOLD  = 4'd5;
    localparam logic [3:0] ADJ_ADD        = 4'd3;

    // Bits needed for an iteration counter that can hold 0..width.
    function automatic int cnt_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

    // Packed pattern of 'digits' nibbles all equal to 9 (saturation value).
    function automatic logic [63:0] all_nines(input int digits);
        logic [63:0] result;
        result = 64'd0;
        for (int i = 0; i < digits; i++) begin
            result = result | (64'(BCD_MAX_NIBBLE) << (4 * i));
        end
        return result;
    endfunction

    // Largest value representable in 'digits' decimal digits.
    function automatic logic [63:0] bcd_limit(input int digits);
        logic [63:0] result;
        result = 64'd1;
        for (int i = 0; i < digits; i++) begin
            result = result * 64'd10;
        end
        return result - 64'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Add 3 to digits at or above the correction threshold, pass others through.
    always_comb begin
        if (digit >= ADJ_THRESHOLD) begin
            adjusted = digit + ADJ_ADD;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one shift/correct iteration per clock,
// start/busy/done handshake, result held stable between conversions.
// Inputs above the decimal range saturate to all-9s with overflow set.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int              BW        = 4 * DIGITS;
    localparam int              CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
    localparam logic [BW-1:0]   NINES     = BW'(all_nines(DIGITS));
    localparam logic [63:0]     LIMIT     = bcd_limit(DIGITS);

    state_t                 state_r, state_s;
    logic [WIDTH-1:0]       shift_r, shift_s;
    logic [BW-1:0]          scratch_r, scratch_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic [BW-1:0]          bcd_r, bcd_s;
    logic                   ovf_r, ovf_s;
    logic                   ovf_pend_r, ovf_pend_s;

    logic [BW-1:0]          adj_s;
    logic [BW+WIDTH-1:0]    combined_s;
    logic [BW+WIDTH-1:0]    shifted_s;

    // One correction unit per scratch digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch_r[4*g +: 4]),
            .adjusted (adj_s[4*g +: 4])
        );
    end

    // Corrected scratch concatenated with the remaining binary bits, shifted left once.
    always_comb begin
        combined_s = {adj_s, shift_r};
        shifted_s  = combined_s << 1'b1;
    end

    // Next-state and next-output logic of the IDLE/CONVERT controller.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        scratch_s  = scratch_r;
        cnt_s      = cnt_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        bcd_s      = bcd_r;
        ovf_s      = ovf_r;
        ovf_pend_s = ovf_pend_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    shift_s    = value;
                    scratch_s  = {BW{1'b0}};
                    cnt_s      = {CW{1'b0}};
                    ovf_pend_s = (64'(value) > LIMIT);
                    busy_s     = 1'b1;
                    state_s    = ST_CONVERT;
                end else begin
                    busy_s     = 1'b0;
                    state_s    = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                shift_s   = shifted_s[WIDTH-1:0];
                scratch_s = shifted_s[BW+WIDTH-1:WIDTH];
                cnt_s     = cnt_r + CW'(1);
                if (cnt_r == LAST_ITER) begin
                    // Final iteration: publish the result and hand control back.
                    bcd_s   = ovf_pend_r ? NINES : shifted_s[BW+WIDTH-1:WIDTH];
                    ovf_s   = ovf_pend_r;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = ST_CONVERT;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion and clears the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= {WIDTH{1'b0}};
            scratch_r  <= {BW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {BW{1'b0}};
            ovf_r      <= 1'b0;
            ovf_pend_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            scratch_r  <= scratch_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            bcd_r      <= bcd_s;
            ovf_r      <= ovf_s;
            ovf_pend_r <= ovf_pend_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd      = bcd_r;
    assign overflow = ovf_r;

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
Sequential double-dabble converter that turns an unsigned binary count into packed BCD digits for the 4-digit seven-segment multiplexer. Its bcd output feeds the display driver's 16-bit nibble input, so the display shows decimal rather than hex. It uses one iteration per clock with a start/busy/done handshake. The output register holds the last result stable between conversions.

Parameters:
WIDTH, 14, bit width of the binary input (14 bits covers 0..9999 plus overflow range)
DIGITS, 4, number of BCD digits produced; bcd width = 4*DIGITS

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
value  input  WIDTH  unsigned binary to convert, sampled on accepted start
start  input  1  request conversion; accepted only when busy=0
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd/overflow just updated
bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0], most-significant digit in top nibble
overflow  output  1  last converted value exceeded 10^DIGITS-1

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, bcd=0, overflow=0, iteration counter=0, shift register=0.
- FSM states are IDLE and CONVERT.
- IDLE: on an edge with start=1, capture value into the shift register, clear the BCD scratch register, set counter=0, set busy=1, and go to CONVERT.
- CONVERT: each edge performs one double-dabble iteration:
  - every scratch digit >=5 gets +3;
  - then {scratch, shift} shifts left by 1;
  - counter increments.
- On the edge doing iteration WIDTH (the last one):
  - load bcd from the final scratch value;
  - set done=1 and busy=0;
  - return to IDLE.
- Latency: start sampled at edge T gives done=1 and a valid bcd in the cycle after edge T+WIDTH (14 cycles at default).
- done is high for exactly one cycle. It is cleared on the next edge unless that edge completes another conversion.
- start while busy=1 is ignored, and value changes during CONVERT have no effect.
- Back-to-back: start=1 in the cycle where done=1 is accepted (state is IDLE). The new conversion begins at that edge and bcd keeps the previous result until its own completion.
- Overflow: if the captured value > 10^DIGITS-1, then at completion bcd = all-9s (0x9999 at default) and overflow=1. Otherwise overflow=0. The comparison uses the value captured at start.
- bcd and overflow change only on a completion edge or reset. They never glitch through intermediate iterations.
- Arithmetic: digit correction is a 4-bit add of 3 on digits 5..9 only. Scratch width is 4*DIGITS and no carry leaves the top digit for in-range inputs.
- Reset asserted mid-conversion: immediate abort to reset values. No done pulse is produced and the previous bcd is lost (bcd=0).
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, CONVERT);
  - BCD_MAX_NIBBLE=4'd9;
  - ADJ_THRESHOLD=4'd5;
  - ADJ_ADD=4'd3;
  - counter width function clog2(WIDTH+1).
- One sub-module, bcd_digit_adj: combinational 4-bit in/out that adds 3 when the input is >=5. It is instantiated DIGITS times via generate.

Test Plan:
- After reset, start with value=0 -> done after 14 cycles, bcd=0x0000, overflow=0, busy high for exactly 14 cycles.
- value=1234 -> bcd=0x1234. Also value=9999 -> bcd=0x9999 with overflow=0. Also value=10 -> bcd=0x0010.
- value=12000 -> bcd=0x9999, overflow=1. A following conversion of value=42 -> bcd=0x0042, overflow=0.
- Start value=500, then pulse start with value=777 at cycle 5 of the conversion -> that second start is ignored; result is 0x0500 and there is exactly one done pulse.
- value=321 completes; in the done cycle assert start with value=8765 -> bcd holds 0x0321 for 14 cycles, then 0x8765 with a second single-cycle done.
- Start value=4321; assert reset asynchronously mid-cycle at iteration 7 -> outputs go to 0 immediately without waiting for an edge and no done pulse appears. After release, value=56 converts to 0x0056.
